// File: rtl/gnt_burst_mux.sv
// gnt_burst_mux
// Burst-level data multiplexer behind the 4-requester round-robin arbiter.
// Samples the encoded grant code while idle, locks onto the granted channel,
// and forwards that channel's valid/ready beats through a one-deep registered
// output stage. The burst ends on the owner's last marker or when the beat
// count reaches MAX_BEATS. Release is signalled by a one-cycle done pulse.
//
// State   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no owner; grant code sampled every edge
// S_ROUTE | owner locked; owner beats accepted into the output register
// S_CLOSE | burst ended; waiting for the output register to drain
//
// Ports
//   clk, rst_n       clock (rising edge), async active-low reset
//   i_gnt            grant code: 0 none, 1..4 = ch0..ch3, 5..F illegal
//   i_ch_valid       per-channel beat valid
//   i_ch_data        per-channel data, channel n at [n*DW +: DW]
//   i_ch_last        per-channel last-beat marker
//   o_ch_ready       per-channel accept (one-hot or zero)
//   o_out_valid      registered output beat valid
//   o_out_data       registered output data
//   o_out_last       registered output last marker
//   i_out_ready      downstream accept
//   o_busy           high in ROUTE and CLOSE
//   o_owner          locked channel index, 0 when idle
//   o_beat_cnt       beats accepted in the current burst
//   o_done           one-cycle pulse at burst release
//   o_err_overrun    one-cycle pulse with done when the burst was force-closed
//   o_err_code       one-cycle pulse after an illegal grant code in IDLE
module gnt_burst_mux #(
   parameter int DW        = 8,
   parameter int MAX_BEATS = 8,
   localparam int CW       = $clog2(MAX_BEATS + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      i_gnt,
   input  logic [3:0]      i_ch_valid,
   input  logic [4*DW-1:0] i_ch_data,
   input  logic [3:0]      i_ch_last,
   output logic [3:0]      o_ch_ready,
   output logic            o_out_valid,
   output logic [DW-1:0]   o_out_data,
   output logic            o_out_last,
   input  logic            i_out_ready,
   output logic            o_busy,
   output logic [1:0]      o_owner,
   output logic [CW-1:0]   o_beat_cnt,
   output logic            o_done,
   output logic            o_err_overrun,
   output logic            o_err_code
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUTE = 2'd1,
      S_CLOSE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [1:0]      r_owner;
   logic [CW-1:0]   r_beat_cnt;
   logic            r_out_valid;
   logic [DW-1:0]   r_out_data;
   logic            r_out_last;
   logic            r_done;
   logic            r_err_overrun;
   logic            r_err_code;
   logic            r_ovr_flag;

   logic [3:0]      w_ch_ready;
   logic            w_slot_free;
   logic            w_accept;
   logic            w_close_ovr;
   logic            w_release;
   logic            w_gnt_ok;
   logic            w_gnt_bad;
   logic [3:0]      w_gnt_m1;
   logic [DW-1:0]   w_sel_data;
   logic            w_sel_valid;
   logic            w_sel_last;
   logic [CW-1:0]   w_cnt_inc;

   assign w_gnt_m1    = i_gnt - 4'd1;
   assign w_cnt_inc   = r_beat_cnt + CW'(1);
   // Output slot can take a beat when empty or draining on this same edge.
   assign w_slot_free = !r_out_valid || i_out_ready;
   assign w_sel_valid = i_ch_valid[r_owner];
   assign w_sel_last  = i_ch_last[r_owner];

   always_comb begin
      w_sel_data = '0;
      case (r_owner)
         2'd0:    w_sel_data = i_ch_data[0*DW +: DW];
         2'd1:    w_sel_data = i_ch_data[1*DW +: DW];
         2'd2:    w_sel_data = i_ch_data[2*DW +: DW];
         default: w_sel_data = i_ch_data[3*DW +: DW];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ch_ready  = '0;
      w_accept    = 1'b0;
      w_close_ovr = 1'b0;
      w_release   = 1'b0;
      w_gnt_ok    = 1'b0;
      w_gnt_bad   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_gnt >= 4'h1 && i_gnt <= 4'h4) begin
               w_gnt_ok    = 1'b1;
               w_state_nxt = S_ROUTE;
            end else if (i_gnt != 4'h0) begin
               w_gnt_bad   = 1'b1;
            end
         end
         S_ROUTE: begin
            w_ch_ready[r_owner] = w_slot_free;
            w_accept = w_sel_valid && w_slot_free;
            if (w_accept) begin
               if (w_sel_last) begin
                  w_state_nxt = S_CLOSE;
               end else if (w_cnt_inc == CW'(MAX_BEATS)) begin
                  w_close_ovr = 1'b1;
                  w_state_nxt = S_CLOSE;
               end
            end
         end
         S_CLOSE: begin
            if (w_slot_free) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner       <= '0;
         r_beat_cnt    <= '0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_last    <= 1'b0;
         r_done        <= 1'b0;
         r_err_overrun <= 1'b0;
         r_err_code    <= 1'b0;
         r_ovr_flag    <= 1'b0;
      end else begin
         r_done        <= w_release;
         r_err_overrun <= w_release && r_ovr_flag;
         r_err_code    <= w_gnt_bad;

         if (w_gnt_ok) begin
            r_owner    <= w_gnt_m1[1:0];
            r_beat_cnt <= '0;
            r_ovr_flag <= 1'b0;
         end
         // beat_cnt is left holding the final count after release.
         if (w_release) begin
            r_owner    <= '0;
            r_ovr_flag <= 1'b0;
         end
         if (w_close_ovr) r_ovr_flag <= 1'b1;

         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= w_sel_last || w_close_ovr;
            r_beat_cnt  <= w_cnt_inc;
         end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_ch_ready    = w_ch_ready;
   assign o_out_valid   = r_out_valid;
   assign o_out_data    = r_out_data;
   assign o_out_last    = r_out_last;
   assign o_busy        = (r_state != S_IDLE);
   assign o_owner       = r_owner;
   assign o_beat_cnt    = r_beat_cnt;
   assign o_done        = r_done;
   assign o_err_overrun = r_err_overrun;
   assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_gnt_burst_mux.sv
// Directed bench for gnt_burst_mux: single burst, backpressure, overrun,
// grant isolation, illegal grant code and asynchronous reset mid-burst.
module tb_gnt_burst_mux;

   localparam int DW = 8;
   localparam int MB = 8;
   localparam int CW = $clog2(MB + 1);

   logic            clk;
   logic            rst_n;
   logic [3:0]      gnt;
   logic [3:0]      ch_valid;
   logic [4*DW-1:0] ch_data;
   logic [3:0]      ch_last;
   logic [3:0]      ch_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic            out_ready;
   logic            busy;
   logic [1:0]      owner;
   logic [CW-1:0]   beat_cnt;
   logic            done;
   logic            err_overrun;
   logic            err_code;

   int n_checks = 0;
   int n_errors = 0;

   gnt_burst_mux #(.DW(DW), .MAX_BEATS(MB)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_gnt         (gnt),
      .i_ch_valid    (ch_valid),
      .i_ch_data     (ch_data),
      .i_ch_last     (ch_last),
      .o_ch_ready    (ch_ready),
      .o_out_valid   (out_valid),
      .o_out_data    (out_data),
      .o_out_last    (out_last),
      .i_out_ready   (out_ready),
      .o_busy        (busy),
      .o_owner       (owner),
      .o_beat_cnt    (beat_cnt),
      .o_done        (done),
      .o_err_overrun (err_overrun),
      .o_err_code    (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(ch_ready), 0);
      chk({tag, "_oval"},  32'(out_valid), 0);
      chk({tag, "_odata"}, 32'(out_data), 0);
      chk({tag, "_olast"}, 32'(out_last), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_owner"}, 32'(owner), 0);
      chk({tag, "_cnt"},   32'(beat_cnt), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_ovr"},   32'(err_overrun), 0);
      chk({tag, "_code"},  32'(err_code), 0);
   endtask

   initial begin
      logic [7:0] bp [4];
      int         src;
      int         rcv;
      logic       done_seen;
      logic [7:0] d;

      rst_n     = 1'b0;
      gnt       = 4'h0;
      ch_valid  = 4'h0;
      ch_data   = '0;
      ch_last   = 4'h0;
      out_ready = 1'b1;
      tick();
      tick();
      chk_all_zero("rst");
      rst_n = 1'b1;
      tick();

      // ---- single burst on ch1 ----
      gnt = 4'h2;
      tick();
      gnt = 4'h0;
      chk("sb_busy", 32'(busy), 1);
      chk("sb_owner", 32'(owner), 1);
      ch_valid = 4'b0010; ch_data = {8'h00, 8'h00, 8'hA1, 8'h00}; ch_last = 4'b0000;
      #1;
      chk("sb_ready0", 32'(ch_ready), 32'h2);
      tick();
      chk("sb_d1", 32'(out_data), 32'hA1);
      chk("sb_v1", 32'(out_valid), 1);
      chk("sb_l1", 32'(out_last), 0);
      chk("sb_c1", 32'(beat_cnt), 1);
      ch_data = {8'h00, 8'h00, 8'hA2, 8'h00};
      tick();
      chk("sb_d2", 32'(out_data), 32'hA2);
      chk("sb_l2", 32'(out_last), 0);
      ch_data = {8'h00, 8'h00, 8'hA3, 8'h00}; ch_last = 4'b0010;
      tick();
      chk("sb_d3", 32'(out_data), 32'hA3);
      chk("sb_l3", 32'(out_last), 1);
      chk("sb_c3", 32'(beat_cnt), 3);
      ch_valid = 4'h0; ch_last = 4'h0;
      #1;
      chk("sb_close_ready", 32'(ch_ready), 0);
      chk("sb_close_done", 32'(done), 0);
      tick();
      chk("sb_done", 32'(done), 1);
      chk("sb_done_busy", 32'(busy), 0);
      chk("sb_done_owner", 32'(owner), 0);
      chk("sb_done_cnt", 32'(beat_cnt), 3);
      chk("sb_done_oval", 32'(out_valid), 0);
      chk("sb_done_ovr", 32'(err_overrun), 0);
      tick();
      chk("sb_done_pulse", 32'(done), 0);

      // ---- backpressure on ch3, out_ready toggling ----
      bp[0] = 8'hB0; bp[1] = 8'hB1; bp[2] = 8'hB2; bp[3] = 8'hB3;
      gnt = 4'h4;
      tick();
      gnt = 4'h0;
      chk("bp_owner", 32'(owner), 3);
      src = 0; rcv = 0; done_seen = 1'b0;
      for (int c = 0; c < 40 && !done_seen; c++) begin
         out_ready = (c % 2 == 0);
         d = (src < 4) ? bp[src] : 8'h00;
         ch_valid = (src < 4) ? 4'b1000 : 4'b0000;
         ch_data  = {d, 24'h0};
         ch_last  = (src == 3) ? 4'b1000 : 4'b0000;
         #1;
         if (out_valid && !out_ready) chk("bp_hold_ready", 32'(ch_ready[3]), 0);
         if (out_valid && out_ready) begin
            if (rcv < 4) begin
               chk("bp_data", 32'(out_data), 32'(bp[rcv]));
               chk("bp_last", 32'(out_last), 32'(rcv == 3));
            end else begin
               chk("bp_extra_beat", 32'(rcv), 3);
            end
            rcv++;
         end
         if (ch_valid[3] && ch_ready[3]) src++;
         tick();
         if (done) done_seen = 1'b1;
      end
      chk("bp_done_seen", 32'(done_seen), 1);
      chk("bp_rcv_count", 32'(rcv), 4);
      ch_valid = 4'h0; ch_last = 4'h0; out_ready = 1'b1;
      tick();

      // ---- overrun on ch0: 10 offered, 8 forwarded ----
      gnt = 4'h1;
      tick();
      gnt = 4'h0;
      ch_valid = 4'b0001; ch_last = 4'h0;
      for (int k = 1; k <= 8; k++) begin
         ch_data = {24'h0, 8'(8'h10 + k - 1)};
         #1;
         chk("ov_ready", 32'(ch_ready), 32'h1);
         tick();
         chk("ov_data", 32'(out_data), 32'(8'h10 + k - 1));
         chk("ov_last", 32'(out_last), 32'(k == 8));
         chk("ov_cnt", 32'(beat_cnt), 32'(k));
      end
      ch_data = {24'h0, 8'h18};
      #1;
      chk("ov_close_ready", 32'(ch_ready), 0);
      tick();
      chk("ov_done", 32'(done), 1);
      chk("ov_err", 32'(err_overrun), 1);
      chk("ov_oval", 32'(out_valid), 0);
      chk("ov_idle_ready", 32'(ch_ready), 0);
      ch_data = {24'h0, 8'h19};
      tick();
      chk("ov_done_pulse", 32'(done), 0);
      chk("ov_err_pulse", 32'(err_overrun), 0);
      chk("ov_after_ready", 32'(ch_ready), 0);
      chk("ov_after_busy", 32'(busy), 0);
      ch_valid = 4'h0;

      // ---- grant isolation on ch2 ----
      gnt = 4'h3;
      tick();
      gnt = 4'h1;
      ch_valid = 4'b1111;
      ch_data  = {8'hD0, 8'hC0, 8'hB9, 8'hA9};
      ch_last  = 4'b1011;
      #1;
      chk("gi_ready", 32'(ch_ready), 32'h4);
      chk("gi_owner", 32'(owner), 2);
      tick();
      chk("gi_d1", 32'(out_data), 32'hC0);
      chk("gi_l1", 32'(out_last), 0);
      chk("gi_owner1", 32'(owner), 2);
      chk("gi_ready1", 32'(ch_ready), 32'h4);
      ch_data = {8'hD1, 8'hC1, 8'hBA, 8'hAA};
      ch_last = 4'b1111;
      tick();
      chk("gi_d2", 32'(out_data), 32'hC1);
      chk("gi_l2", 32'(out_last), 1);
      chk("gi_ready2", 32'(ch_ready), 0);
      chk("gi_owner2", 32'(owner), 2);
      tick();
      chk("gi_done", 32'(done), 1);
      chk("gi_done_owner", 32'(owner), 0);
      gnt = 4'h0; ch_valid = 4'h0; ch_last = 4'h0;
      tick();
      chk("gi_idle_busy", 32'(busy), 0);

      // ---- illegal grant code ----
      gnt = 4'h7;
      tick();
      gnt = 4'h0;
      chk("ic_err", 32'(err_code), 1);
      chk("ic_busy", 32'(busy), 0);
      tick();
      chk("ic_err_pulse", 32'(err_code), 0);
      chk("ic_busy2", 32'(busy), 0);

      // ---- async reset mid-burst ----
      gnt = 4'h1;
      tick();
      gnt = 4'h0;
      ch_valid = 4'b0001; ch_data = {24'h0, 8'h55}; out_ready = 1'b0;
      tick();
      chk("ar_oval", 32'(out_valid), 1);
      chk("ar_odata", 32'(out_data), 32'h55);
      ch_valid = 4'h0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("ar");
      out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("ar_no_done", 32'(done), 0);
         chk("ar_no_busy", 32'(busy), 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
